// File: rtl/temporizador_giro_360_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_giro_360_pkg
// Description : Shared types and constants for the face-move rotation timer:
//               state encoding, default timing constants, counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package temporizador_giro_360_pkg;

   // System clock frequency; the default timings below are derived from it
   localparam int FREQ_CLOCK_HZ = 50_000_000;

   // 0.5 s of rotation per quarter turn
   localparam int CICLOS_QUARTO_PADRAO = FREQ_CLOCK_HZ / 2;

   // 100 ms of stopped servo before completion is reported
   localparam int CICLOS_ASSENTAMENTO_PADRAO = FREQ_CLOCK_HZ / 10;

   // FSM state encoding; the value is also exported on db_estado
   typedef enum logic [1:0] {
      REPOUSO = 2'd0,
      GIRA    = 2'd1,
      ASSENTA = 2'd2,
      FIM     = 2'd3
   } estado_t;

   // Counter width: must hold 3 quarter turns minus one, and also the
   // settling reload value (only relevant for unusual parameter sets).
   function automatic int largura_contador(input int ciclos_quarto,
                                           input int ciclos_assentamento);
      int w_giro;
      int w_assenta;
      w_giro    = $clog2(3 * ciclos_quarto);
      w_assenta = $clog2(ciclos_assentamento);
      if (w_assenta > w_giro) begin
         w_giro = w_assenta;
      end
      if (w_giro < 1) begin
         w_giro = 1;
      end
      return w_giro;
   endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_giro_360_if.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_giro_360_if
// Description : Handshake between the move sequencer (master) and the
//               rotation timer (slave), plus the servo command and debug.
// Revision    : 1.0 - initial release
// ============================================================================
interface temporizador_giro_360_if;

   logic       iniciar;    // start request
   logic [1:0] quartos;    // quarter turns, captured with iniciar
   logic       cancelar;   // abort, any state
   logic       posicao;    // servo command: 1 = rotate, 0 = stop
   logic       ocupado;    // move in progress
   logic       pronto;     // one-cycle completion pulse
   logic [1:0] db_estado;  // current state, debug

   // Sequencer side
   modport master (
      output iniciar,
      output quartos,
      output cancelar,
      input  posicao,
      input  ocupado,
      input  pronto,
      input  db_estado
   );

   // Timer side
   modport slave (
      input  iniciar,
      input  quartos,
      input  cancelar,
      output posicao,
      output ocupado,
      output pronto,
      output db_estado
   );

endinterface
`default_nettype wire

// File: rtl/temporizador_giro_360_contador_regressivo.sv
`default_nettype none
// ============================================================================
// Module      : contador_regressivo
// Description : Loadable down-counter. Load has priority over decrement;
//               the count saturates at zero and flags it on 'zero'.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_regressivo
   import temporizador_giro_360_pkg::*;
#(
   parameter int LARGURA = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               carrega,
   input  logic               decrementa,
   input  logic [LARGURA-1:0] valor,
   output logic               zero
);

   logic [LARGURA-1:0] r_conta;

   // Count register: load wins, otherwise step down until reaching zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_conta <= '0;
      end else if (carrega) begin
         r_conta <= valor;
      end else if (decrementa && (r_conta != '0)) begin
         r_conta <= r_conta - LARGURA'(1);
      end
   end

   assign zero = (r_conta == '0);

endmodule
`default_nettype wire

// File: rtl/temporizador_giro_360.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_giro_360
// Description : Sequences one face move for the continuous-rotation servo:
//               rotate for N quarter-turn periods, hold stopped for a settling
//               interval, then pulse completion. Outputs decode the state
//               register directly, so reset drops them asynchronously.
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_giro_360
   import temporizador_giro_360_pkg::*;
#(
   parameter int CICLOS_QUARTO       = CICLOS_QUARTO_PADRAO,
   parameter int CICLOS_ASSENTAMENTO = CICLOS_ASSENTAMENTO_PADRAO
) (
   input  logic                  clock,
   input  logic                  reset,
   temporizador_giro_360_if.slave bus
);

   localparam int LARGURA = largura_contador(CICLOS_QUARTO, CICLOS_ASSENTAMENTO);

   localparam logic [LARGURA-1:0] C_QUARTO        = LARGURA'(CICLOS_QUARTO);
   localparam logic [LARGURA-1:0] C_ASSENTA_FINAL = LARGURA'(CICLOS_ASSENTAMENTO - 1);
   localparam logic [LARGURA-1:0] C_UM            = LARGURA'(1);

   estado_t            r_estado;
   estado_t            w_proximo;
   logic               w_carrega;
   logic               w_decrementa;
   logic               w_zero;
   logic [LARGURA-1:0] w_valor;
   logic [LARGURA-1:0] w_carga_giro;

   // Rotation reload: quartos widened before the multiply so that
   // 3 x CICLOS_QUARTO never truncates; the counter ends on 0, hence -1.
   assign w_carga_giro = (LARGURA'(bus.quartos) * C_QUARTO) - C_UM;

   contador_regressivo #(
      .LARGURA (LARGURA)
   ) u_contador (
      .clock      (clock),
      .reset      (reset),
      .carrega    (w_carrega),
      .decrementa (w_decrementa),
      .valor      (w_valor),
      .zero       (w_zero)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= REPOUSO;
      end else begin
         r_estado <= w_proximo;
      end
   end

   // Next-state and counter control
   always_comb begin
      w_proximo    = r_estado;
      w_carrega    = 1'b0;
      w_decrementa = 1'b0;
      w_valor      = '0;

      case (r_estado)
         REPOUSO: begin
            // cancelar outranks iniciar; quartos is captured only here
            if (bus.iniciar && !bus.cancelar) begin
               if (bus.quartos != 2'd0) begin
                  w_carrega = 1'b1;
                  w_valor   = w_carga_giro;
                  w_proximo = GIRA;
               end else begin
                  // zero quarter turns: report completion with no rotation
                  w_proximo = FIM;
               end
            end
         end

         GIRA: begin
            if (bus.cancelar) begin
               w_proximo = REPOUSO;
            end else if (w_zero) begin
               w_carrega = 1'b1;
               w_valor   = C_ASSENTA_FINAL;
               w_proximo = ASSENTA;
            end else begin
               w_decrementa = 1'b1;
            end
         end

         ASSENTA: begin
            if (bus.cancelar) begin
               w_proximo = REPOUSO;
            end else if (w_zero) begin
               w_proximo = FIM;
            end else begin
               w_decrementa = 1'b1;
            end
         end

         FIM: begin
            // single-cycle completion; a new start is taken from REPOUSO
            w_proximo = REPOUSO;
         end

         default: begin
            w_proximo = REPOUSO;
         end
      endcase
   end

   assign bus.posicao   = (r_estado == GIRA);
   assign bus.ocupado   = (r_estado != REPOUSO);
   assign bus.pronto    = (r_estado == FIM);
   assign bus.db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_giro_360.sv
`default_nettype none
// ============================================================================
// Module      : tb_temporizador_giro_360
// Description : Self-checking bench for temporizador_giro_360 with
//               CICLOS_QUARTO=10, CICLOS_ASSENTAMENTO=4. Each scoreboard
//               entry holds the expected {posicao,ocupado,pronto,db_estado}
//               for one cycle and the inputs to drive after that sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador_giro_360;

   localparam int CQ = 10;
   localparam int CA = 4;

   // {posicao, ocupado, pronto, db_estado}
   localparam logic [4:0] E_IDLE = 5'b000_00;
   localparam logic [4:0] E_GIRA = 5'b110_01;
   localparam logic [4:0] E_ASS  = 5'b010_10;
   localparam logic [4:0] E_FIM  = 5'b011_11;

   typedef struct {
      logic [4:0] exp;
      logic       ini;
      logic [1:0] q;
      logic       can;
   } step_t;

   logic  clock;
   logic  reset;
   int    checks;
   int    failures;
   step_t sb[$];

   temporizador_giro_360_if bus ();

   temporizador_giro_360 #(
      .CICLOS_QUARTO       (CQ),
      .CICLOS_ASSENTAMENTO (CA)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Queue n identical steps
   task automatic push(input logic [4:0] e, input logic ini, input logic [1:0] q,
                       input logic can, input int n);
      for (int i = 0; i < n; i++) begin
         sb.push_back('{exp: e, ini: ini, q: q, can: can});
      end
   endtask

   // Expected timeline of an uninterrupted move of q quarter turns
   task automatic push_move(input int q);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, q * CQ);
      push(E_ASS,  1'b0, 2'd0, 1'b0, CA);
      push(E_FIM,  1'b0, 2'd0, 1'b0, 1);
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 2);
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      reset = 1'b1;
      bus.iniciar = 1'b0; bus.quartos = 2'd0; bus.cancelar = 1'b0;
      repeat (3) @(negedge clock);
      obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
      checks++;
      if (obs !== E_IDLE) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=%b", obs, E_IDLE);
      end
      reset = 1'b0;
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 20);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   task automatic test_um_quarto();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      push(E_IDLE, 1'b1, 2'd1, 1'b0, 1);
      push_move(1);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL um_quarto cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      push(E_IDLE, 1'b1, 2'd3, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, 3 * CQ);
      push(E_ASS,  1'b0, 2'd0, 1'b0, CA);
      // iniciar already high during FIM must not act there, only one cycle later
      push(E_FIM,  1'b1, 2'd1, 1'b0, 1);
      push(E_IDLE, 1'b1, 2'd1, 1'b0, 1);
      push_move(1);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   task automatic test_zero_and_ignore();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      // zero quarter turns: straight to FIM, no rotation
      push(E_IDLE, 1'b1, 2'd0, 1'b0, 1);
      push(E_FIM,  1'b0, 2'd0, 1'b0, 1);
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 3);
      // two quarter turns with a stray iniciar and quartos change mid-rotation
      push(E_IDLE, 1'b1, 2'd2, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd2, 1'b0, 2);
      push(E_GIRA, 1'b1, 2'd3, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd1, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, 2 * CQ - 4);
      push(E_ASS,  1'b0, 2'd0, 1'b0, CA);
      push(E_FIM,  1'b0, 2'd0, 1'b0, 1);
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 2);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL zero_ignore cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   task automatic test_cancel();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      push(E_IDLE, 1'b1, 2'd2, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, 4);
      push(E_GIRA, 1'b0, 2'd0, 1'b1, 1);   // cancelar seen at the edge ending cycle 5
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 6);   // no pronto afterwards
      // iniciar together with cancelar in REPOUSO: no start
      push(E_IDLE, 1'b1, 2'd1, 1'b1, 1);
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 5);
      // cancel during settling as well
      push(E_IDLE, 1'b1, 2'd1, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, CQ);
      push(E_ASS,  1'b0, 2'd0, 1'b1, 1);
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 6);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL cancel cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   task automatic test_async_reset();
      logic [4:0] obs;
      step_t      s;
      int         cyc;
      push(E_IDLE, 1'b1, 2'd2, 1'b0, 1);
      push(E_GIRA, 1'b0, 2'd0, 1'b0, 3);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL async_pre cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
      // assert reset between edges, well away from any clock edge
      @(posedge clock);
      #2;
      obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
      checks++;
      if (obs !== E_GIRA) begin
         failures++;
         $display("FAIL async_before got=%b exp=%b", obs, E_GIRA);
      end
      reset = 1'b1;
      #1;
      obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
      checks++;
      if (obs !== E_IDLE) begin
         failures++;
         $display("FAIL async_drop got=%b exp=%b", obs, E_IDLE);
      end
      @(negedge clock);
      reset = 1'b0;
      // fresh two-quarter move after release
      push(E_IDLE, 1'b0, 2'd0, 1'b0, 2);
      push(E_IDLE, 1'b1, 2'd2, 1'b0, 1);
      push_move(2);
      cyc = 0;
      while (sb.size() > 0) begin
         @(negedge clock);
         s = sb.pop_front();
         obs = {bus.posicao, bus.ocupado, bus.pronto, bus.db_estado};
         checks++;
         if (obs !== s.exp) begin
            failures++;
            $display("FAIL async_after cyc=%0d got=%b exp=%b", cyc, obs, s.exp);
         end
         bus.iniciar = s.ini; bus.quartos = s.q; bus.cancelar = s.can;
         cyc++;
      end
   endtask

   // Bound on total run time
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_um_quarto();
      test_back_to_back();
      test_zero_and_ignore();
      test_cancel();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/temporizador_giro_360.md
# temporizador_giro_360

Sequences one face move for the continuous-rotation servo path. On a start request it holds the 1-bit `posicao` command high (rotate) for exactly N quarter-turn periods, then holds it low (stop) for a settling interval, then reports completion. It sits directly upstream of the servo PWM controller: its `posicao` output drives that controller's `posicao` input, and its handshake faces the move sequencer.

## Interface
- `CICLOS_QUARTO`, default 25_000_000 (0.5 s at 50 MHz): clock cycles of rotation per quarter turn.
- `CICLOS_ASSENTAMENTO`, default 5_000_000 (100 ms): clock cycles the servo is held stopped after rotation before completion is reported.
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `iniciar`  in  1  start request; sampled only in REPOUSO.
- `quartos`  in  2  number of quarter turns, 0..3; sampled together with `iniciar`.
- `cancelar`  in  1  abort; effective in any state.
- `posicao`  out  1  servo command: 1 = rotate, 0 = stop.
- `ocupado`  out  1  high in every state except REPOUSO.
- `pronto`  out  1  one-cycle pulse on normal completion.
- `db_estado`  out  2  current state encoding, for debug.

## Operation
- States: REPOUSO=0, GIRA=1, ASSENTA=2, FIM=3.
- REPOUSO: if `iniciar`=1, `cancelar`=0 and `quartos`≠0, latch the counter to `quartos`×`CICLOS_QUARTO`−1 and go to GIRA.
- REPOUSO with `iniciar`=1 and `quartos`=0: skip to FIM with no rotation, so `posicao` is never asserted.
- GIRA: `posicao`=1. Decrement the counter each cycle. When the counter is 0, load `CICLOS_ASSENTAMENTO`−1 and go to ASSENTA.
- ASSENTA: `posicao`=0. Decrement each cycle. When the counter is 0, go to FIM.
- FIM: `pronto`=1 for this single cycle, then go to REPOUSO.
- `cancelar`=1 in GIRA, ASSENTA or FIM: go to REPOUSO on the next edge and suppress `pronto`.
- `cancelar` has priority over `iniciar` when both are high in REPOUSO: no start.
- `iniciar` is ignored while `ocupado`=1. No queuing.
- Counter width is clog2(3×`CICLOS_QUARTO`). The product `quartos`×`CICLOS_QUARTO` is computed at that width and must not truncate.
- `quartos` is captured only at start. Changes during a move have no effect.

## Timing
- All outputs are registered, decoded from state: `posicao`=(estado==GIRA), `ocupado`=(estado≠REPOUSO), `pronto`=(estado==FIM).
- Reset values: state REPOUSO, counter 0, `posicao`=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
- If `iniciar` is seen at edge k, `posicao` rises after edge k and stays high for exactly `quartos`×`CICLOS_QUARTO` cycles.
- `pronto` goes high exactly `CICLOS_ASSENTAMENTO` cycles after `posicao` falls.
- Total from the start edge to the `pronto` cycle: q×`CICLOS_QUARTO` + `CICLOS_ASSENTAMENTO` + 1 cycles.
- A new `iniciar` is accepted in the cycle after `pronto`.
- The `quartos`=0 path: `pronto` goes high 1 cycle after the start edge.
- Cancel: `posicao` falls and `ocupado` falls 1 cycle after the `cancelar` edge.
- Reset mid-move: `posicao` drops asynchronously and immediately. No `pronto` is produced.

## Structure
- A shared package holds:
  - the state enum (REPOUSO, GIRA, ASSENTA, FIM, 2-bit);
  - the default constants `CICLOS_QUARTO_PADRAO` and `CICLOS_ASSENTAMENTO_PADRAO`;
  - the 50 MHz clock constant.
- One sub-module: `contador_regressivo`, a parameterised-width loadable down-counter with `carrega`, `valor` and `zero`. The FSM instantiates it once.

## Test plan
All scenarios use `CICLOS_QUARTO`=10 and `CICLOS_ASSENTAMENTO`=4.
- Reset then idle 20 cycles → `posicao`=`ocupado`=`pronto`=0 and `db_estado`=0 throughout.
- `iniciar` pulse with `quartos`=1 → `posicao` high exactly 10 cycles, low 4 cycles, then `pronto` for 1 cycle on cycle 15 after start. `ocupado` high cycles 1–15.
- `quartos`=3 → `posicao` high exactly 30 cycles. `pronto` on cycle 35. Re-issue `iniciar` the cycle after `pronto` → accepted.
- `quartos`=0 → `posicao` never high, `pronto` on cycle 1. Also: `iniciar` pulsed again during GIRA → ignored, and the timing of the first move is unchanged.
- `cancelar` on cycle 5 of GIRA → `posicao` and `ocupado` fall next cycle, no `pronto`. Also: `iniciar`+`cancelar` together in REPOUSO → no start.
- Assert `reset` asynchronously mid-GIRA (between edges) → `posicao` falls immediately and the state returns to REPOUSO. After release, a fresh `quartos`=2 move gives 20 cycles high.
